// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates an instruction-fetch port and a load/store port onto a
// single-port, byte-wide RAM with one cycle of read latency. Each access is
// serialised into N byte cycles (N = 1, 2 or 4), little-endian.
//
// Ports
//   clk        clock, all state updates on rising edge
//   rst        asynchronous active-low reset
//   if_req     fetch request, held until if_ready
//   if_addr    fetch byte address (always 4 bytes)
//   if_ready   one-cycle completion pulse for the fetch
//   if_data    fetched word, held outside the completion cycle
//   mem_req    load/store request, held until mem_ready
//   mem_we     1 = store, 0 = load
//   mem_addr   load/store byte address
//   mem_len    00 byte, 01 half, 10 word, 11 treated as word
//   mem_wdata  store data, byte k = bits [8k+7:8k]
//   mem_ready  one-cycle completion pulse for load/store
//   mem_rdata  zero-extended load data, held outside the completion cycle
//   ram_addr   byte address to the RAM (0 when idle)
//   ram_dout   write byte to the RAM
//   ram_wr     RAM write strobe
//   ram_din    RAM read byte, valid one cycle after ram_addr
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  // Requester identifiers used by id_q and last_grant_q.
  localparam logic GrantIf  = 1'b0;
  localparam logic GrantMem = 1'b1;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;         // byte cycle index within READ/WRITE (k-1)
  logic [2:0]  len_q, len_d;         // transfer length N in bytes
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic        id_q, id_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] result_q, result_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic        grant_mem;
  logic [2:0]  mem_len_bytes;
  logic [1:0]  cap_idx;

  // Reserved length encoding falls through to a word access.
  always_comb begin
    unique case (mem_len)
      2'b00:   mem_len_bytes = 3'd1;
      2'b01:   mem_len_bytes = 3'd2;
      default: mem_len_bytes = 3'd4;
    endcase
  end

  // IF only beats a simultaneous mem request right after a mem grant.
  assign grant_mem = mem_req && !(last_grant_q == GrantMem && if_req);

  // ram_din arriving in cycle k+1 belongs to result byte k-1 = cnt_q-1.
  assign cap_idx = cnt_q[1:0] - 2'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    if_data_d    = if_data_q;
    mem_rdata_d  = mem_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (if_req || mem_req) begin
          id_d         = grant_mem;
          last_grant_d = grant_mem;
          base_d       = grant_mem ? mem_addr : if_addr;
          len_d        = grant_mem ? mem_len_bytes : 3'd4;
          wdata_d      = mem_wdata;
          cnt_d        = 3'd0;
          result_d     = 32'd0;
          state_d      = (grant_mem && mem_we) ? StWrite : StRead;
        end
      end
      StRead: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q != 3'd0) begin
          result_d[{cap_idx, 3'b000} +: 8] = ram_din;
        end
        // Final byte lands this edge; publish the assembled word for DONE.
        if (cnt_q == len_q) begin
          state_d = StDone;
          if (id_q == GrantMem) begin
            mem_rdata_d = result_d;
          end else begin
            if_data_d = result_d;
          end
        end
      end
      StWrite: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == len_q - 3'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      len_q        <= 3'd0;
      base_q       <= 32'd0;
      wdata_q      <= 32'd0;
      id_q         <= GrantIf;
      last_grant_q <= GrantIf;
      result_q     <= 32'd0;
      if_data_q    <= 32'd0;
      mem_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      if_data_q    <= if_data_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  // Outputs decoded from registered state only; reset of state_q forces them
  // to zero immediately.
  always_comb begin
    ram_addr = 32'd0;
    ram_dout = 8'd0;
    ram_wr   = 1'b0;
    unique case (state_q)
      StRead: begin
        // The extra (N+1)th cycle only collects the last byte.
        if (cnt_q < len_q) begin
          ram_addr = base_q + {29'd0, cnt_q};
        end
      end
      StWrite: begin
        ram_wr   = 1'b1;
        ram_addr = base_q + {29'd0, cnt_q};
        ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      end
      default: begin
        ram_addr = 32'd0;
      end
    endcase
  end

  assign if_ready  = (state_q == StDone) && (id_q == GrantIf);
  assign mem_ready = (state_q == StDone) && (id_q == GrantMem);
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte-wide RAM model (4 KiB window,
// indexed by address bits [11:0]) having one cycle of read latency.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = 8'h00;

  logic [7:0]  ram [0:4095] = '{default: 8'h00};
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [7:0]  pl_data = 8'd0;

  logic [31:0] addr_log [1:12];
  logic        wr_log   [1:12];
  logic [7:0]  dout_log [1:12];

  int checks = 0;
  int failures = 0;

  mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_data   (if_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_len   (mem_len),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
    else if (pl_we) ram[pl_addr] <= pl_data;
    ram_din <= ram[ram_addr[11:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    @(negedge clk);
    pl_we   = 1'b0;
  endtask

  // Called at a negedge with requests already driven; the first negedge
  // inside is cycle 1 after the grant edge. rdy = cycle of the ready pulse.
  task automatic run_txn(input bit want_mem, input int max_cyc, output int rdy);
    rdy = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      addr_log[k] = ram_addr;
      wr_log[k]   = ram_wr;
      dout_log[k] = ram_dout;
      if ((want_mem ? mem_ready : if_ready) === 1'b1) begin
        rdy = k;
        break;
      end
    end
  endtask

  task automatic set_mem(input logic we, input logic [31:0] a, input logic [1:0] len,
                         input logic [31:0] wd);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = a;
    mem_len   = len;
    mem_wdata = wd;
  endtask

  initial begin
    int rdy;
    int seen;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_len = '0; mem_wdata = '0;
    @(negedge clk);
    check_eq("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check_eq("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check_eq("rst_if_data", if_data, 32'd0);
    check_eq("rst_mem_rdata", mem_rdata, 32'd0);
    check_eq("rst_ram_addr", ram_addr, 32'd0);
    check_eq("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check_eq("rst_ram_wr", {31'd0, ram_wr}, 32'd0);

    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    poke(12'h200, 8'hA0); poke(12'h201, 8'hA1); poke(12'h202, 8'hA2); poke(12'h203, 8'hA3);
    poke(12'h022, 8'h5A); poke(12'hFFF, 8'h80); poke(12'hFFE, 8'h7F);
    poke(12'h000, 8'h01); poke(12'h001, 8'h02);
    rst = 1'b1;
    @(negedge clk);

    // Word fetch.
    if_req = 1'b1; if_addr = 32'h100;
    run_txn(1'b0, 10, rdy);
    if_req = 1'b0;
    check_eq("fetch_latency", rdy, 32'd6);
    check_eq("fetch_data", if_data, 32'h44332211);
    for (int k = 1; k <= 4; k++) check_eq("fetch_addr", addr_log[k], 32'h100 + k - 1);
    check_eq("fetch_addr_c5", addr_log[5], 32'd0);
    seen = 0;
    for (int k = 1; k <= 5; k++) seen += int'(wr_log[k]);
    check_eq("fetch_no_wr", seen, 32'd0);
    @(negedge clk);
    check_eq("fetch_ready_pulse", {31'd0, if_ready}, 32'd0);
    check_eq("fetch_data_hold", if_data, 32'h44332211);

    // Simultaneous requests with last_grant=IF: mem first, then IF, then mem.
    if_req = 1'b1; if_addr = 32'h200;
    set_mem(1'b0, 32'h101, 2'b00, 32'h0);
    run_txn(1'b1, 8, rdy);
    check_eq("arb1_latency", rdy, 32'd3);
    check_eq("arb1_rdata", mem_rdata, 32'h22);
    check_eq("arb1_addr", addr_log[1], 32'h101);
    check_eq("arb1_addr_c2", addr_log[2], 32'd0);
    @(negedge clk);
    check_eq("arb1_ready_pulse", {31'd0, mem_ready}, 32'd0);
    run_txn(1'b0, 10, rdy);
    check_eq("arb2_latency", rdy, 32'd6);
    check_eq("arb2_addr", addr_log[1], 32'h200);
    check_eq("arb2_data", if_data, 32'hA3A2A1A0);
    @(negedge clk);
    run_txn(1'b1, 8, rdy);
    check_eq("arb3_latency", rdy, 32'd3);
    check_eq("arb3_rdata", mem_rdata, 32'h22);
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);

    // Byte load at top of address space.
    set_mem(1'b0, 32'hFFFF_FFFF, 2'b00, 32'h0);
    run_txn(1'b1, 8, rdy);
    mem_req = 1'b0;
    check_eq("ld_b_latency", rdy, 32'd3);
    check_eq("ld_b_addr", addr_log[1], 32'hFFFF_FFFF);
    check_eq("ld_b_rdata", mem_rdata, 32'h0000_0080);
    @(negedge clk);

    // Half load.
    set_mem(1'b0, 32'h101, 2'b01, 32'h0);
    run_txn(1'b1, 8, rdy);
    mem_req = 1'b0;
    check_eq("ld_h_latency", rdy, 32'd4);
    check_eq("ld_h_rdata", mem_rdata, 32'h0000_3322);
    @(negedge clk);

    // Word load wrapping through zero.
    set_mem(1'b0, 32'hFFFF_FFFE, 2'b10, 32'h0);
    run_txn(1'b1, 10, rdy);
    mem_req = 1'b0;
    check_eq("ld_w_latency", rdy, 32'd6);
    check_eq("ld_w_addr1", addr_log[1], 32'hFFFF_FFFE);
    check_eq("ld_w_addr2", addr_log[2], 32'hFFFF_FFFF);
    check_eq("ld_w_addr3", addr_log[3], 32'h0000_0000);
    check_eq("ld_w_addr4", addr_log[4], 32'h0000_0001);
    check_eq("ld_w_rdata", mem_rdata, 32'h0201_807F);
    @(negedge clk);

    // Half store.
    set_mem(1'b1, 32'h20, 2'b01, 32'hAABB_CCDD);
    run_txn(1'b1, 8, rdy);
    mem_req = 1'b0;
    check_eq("st_h_latency", rdy, 32'd3);
    check_eq("st_h_wr1", {31'd0, wr_log[1]}, 32'd1);
    check_eq("st_h_wr2", {31'd0, wr_log[2]}, 32'd1);
    check_eq("st_h_wr3", {31'd0, wr_log[3]}, 32'd0);
    check_eq("st_h_addr1", addr_log[1], 32'h20);
    check_eq("st_h_addr2", addr_log[2], 32'h21);
    check_eq("st_h_dout1", {24'd0, dout_log[1]}, 32'hDD);
    check_eq("st_h_dout2", {24'd0, dout_log[2]}, 32'hCC);
    check_eq("st_h_rdata_hold", mem_rdata, 32'h0201_807F);
    @(negedge clk);
    check_eq("st_h_ram20", {24'd0, ram[12'h020]}, 32'hDD);
    check_eq("st_h_ram21", {24'd0, ram[12'h021]}, 32'hCC);
    check_eq("st_h_ram22", {24'd0, ram[12'h022]}, 32'h5A);

    // Reset during cycle 2 of a word store.
    set_mem(1'b1, 32'h40, 2'b10, 32'h1122_3344);
    @(negedge clk);
    check_eq("abort_c1_wr", {31'd0, ram_wr}, 32'd1);
    check_eq("abort_c1_dout", {24'd0, ram_dout}, 32'h44);
    @(negedge clk);
    check_eq("abort_c2_addr", ram_addr, 32'h41);
    rst = 1'b0;
    mem_req = 1'b0;
    #1;
    check_eq("abort_wr_drop", {31'd0, ram_wr}, 32'd0);
    check_eq("abort_addr_zero", ram_addr, 32'd0);
    check_eq("abort_rdata_clr", mem_rdata, 32'd0);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seen += int'(mem_ready) + int'(ram_wr);
    end
    check_eq("abort_no_ready", seen, 32'd0);
    check_eq("abort_ram40", {24'd0, ram[12'h040]}, 32'h44);
    check_eq("abort_ram41", {24'd0, ram[12'h041]}, 32'h00);
    rst = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    run_txn(1'b0, 10, rdy);
    if_req = 1'b0;
    check_eq("post_rst_latency", rdy, 32'd6);
    check_eq("post_rst_data", if_data, 32'h44332211);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 if_req  in  1  instruction-fetch request, held high until if_ready seen.
REQ-004 if_addr  in  32  fetch byte address; fetches always 4 bytes.
REQ-005 if_ready  out  1  one-cycle pulse: fetch complete, if_data valid.
REQ-006 if_data  out  32  fetched word, little-endian.
REQ-007 mem_req  in  1  load/store request, held high until mem_ready seen.
REQ-008 mem_we  in  1  1 = store, 0 = load.
REQ-009 mem_addr  in  32  load/store byte address.
REQ-010 mem_len  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-011 mem_wdata  in  32  store data; byte k = bits [8k+7:8k].
REQ-012 mem_ready  out  1  one-cycle pulse: load/store complete, mem_rdata valid for loads.
REQ-013 mem_rdata  out  32  load data, zero-extended; sign extension is done downstream.
REQ-014 ram_addr  out  32  byte address to the single-port, byte-wide RAM.
REQ-015 ram_dout  out  8  write byte to RAM.
REQ-016 ram_wr  out  1  RAM write strobe for the current cycle.
REQ-017 ram_din  in  8  RAM read byte, valid one cycle after ram_addr is presented.

Function
REQ-018 FSM states SHALL be IDLE, READ, WRITE and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-019 In IDLE, at a clock edge with any request high, the block SHALL latch the winner's address, length N (1/2/4), store data and requester ID, then enter READ (fetch or load) or WRITE (store).
REQ-020 Arbitration: mem_req SHALL win simultaneous requests, except when the previous grant was mem and if_req is high, in which case IF SHALL win.
REQ-021 A last_grant register SHALL record the requester on every grant.
REQ-022 READ, cycles 1..N+1 after the grant edge: in cycle k (k<=N), ram_addr = base+(k-1).
REQ-023 READ: at the edge ending cycle k+1, the block SHALL capture ram_din into result byte k-1.
REQ-024 READ: after cycle N+1 the FSM SHALL enter DONE.
REQ-025 WRITE, cycles 1..N: in cycle k, ram_wr=1, ram_addr=base+(k-1) and ram_dout = store byte k-1; after cycle N the FSM SHALL enter DONE.
REQ-026 DONE lasts exactly one cycle: the granted requester's ready SHALL be 1 and its data output valid; the FSM SHALL then return to IDLE.
REQ-027 Requests SHALL NOT be sampled in DONE.
REQ-028 Latency from the grant edge: word read ready in cycle 6, half in 4, byte in 3; word write ready in cycle 5, half in 3, byte in 2.
REQ-029 Address increment SHALL wrap modulo 2^32; no alignment check.
REQ-030 Unfilled result bytes SHALL be 0.
REQ-031 if_data and mem_rdata SHALL hold their last value outside DONE.
REQ-032 In IDLE and DONE: ram_wr=0, ram_addr=0, ram_dout=0.
REQ-033 ram_wr SHALL never be 1 outside WRITE.
REQ-034 Request inputs changing during a transaction SHALL be ignored; latched values govern.

Reset
REQ-035 rst=0 SHALL immediately force IDLE and last_grant=IF, and clear if_ready, mem_ready, if_data, mem_rdata, ram_addr, ram_dout and ram_wr to 0.
REQ-036 Reset mid-transaction SHALL abort with no ready pulse and no further RAM write.
REQ-037 After release, the first sampled request SHALL be arbitrated normally.

Verification
REQ-038 RAM[0x100..0x103]=11,22,33,44, if_req with if_addr=0x100 -> ram_addr 0x100..0x103 in cycles 1-4, if_ready=1 in cycle 6 only, if_data=0x44332211.
REQ-039 Store, mem_len=01, mem_addr=0x20, mem_wdata=0xAABBCCDD -> ram_wr cycles 1-2 with (0x20,DD),(0x21,CC), mem_ready in cycle 3, RAM[0x22] unchanged.
REQ-040 if_req and mem_req (load) both high from IDLE, last_grant=IF -> mem served first; on the next IDLE IF is served although mem_req is reasserted.
REQ-041 Byte load at 0xFFFFFFFF, RAM byte 0x80 -> mem_rdata=0x00000080; word load at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
REQ-042 rst=0 during cycle 2 of a word store -> ram_wr drops immediately, no mem_ready, only byte 0 written; after release a new if_req completes normally.
